leg_io_uart_tx: RTL and testbench
=================================

// Module: leg_io_uart_tx
// PURPOSE
// - Output-port peripheral downstream of the LEG CPU core: consumes the core's true-polarity 8-bit io_out bus.
// - Captures every new value the program writes to the port, buffers it in a small FIFO and sends it as 8N1 UART frames.
// - Lets a host terminal observe program output without a strobe from the core.
// PARAMETERS
// - CLKS_PER_BIT  434  clk cycles per UART bit (must be >= 2)
// - FIFO_DEPTH    4    byte entries, power of two, >= 2
// PORTS
// - clk        in   1   system clock, all logic on rising edge
// - rst        in   1   asynchronous, active-high reset
// - io_out     in   8   core output port, true polarity
// - tx_en      in   1   1 = new frames may start; 0 = hold queued bytes
// - tx         out  1   UART serial line, idle high
// - busy       out  1   1 while a frame is on the line
// - fifo_level out  $clog2(FIFO_DEPTH)+1  entries currently queued
// - overflow   out  1   sticky: a captured byte was dropped
// BEHAVIOUR
// - Reset: tx=1, busy=0, fifo_level=0, overflow=0, prev_q=8'h00, FSM=IDLE, baud and bit counters=0.
// - Capture: io_out registered to io_q; push when io_q != prev_q; prev_q<=io_q that cycle.
// - A push occurs 2 clk after io_out changes; a constant bus never pushes; writing 8'h00 after reset never pushes.
// - FIFO: circular write/read pointers wrap at FIFO_DEPTH; occupancy counter sized to hold FIFO_DEPTH.
// - Push when full and no pop that cycle: byte dropped, overflow<=1; cleared only by rst.
// - Push and pop in the same cycle: both happen, even when full; level unchanged.
// - Pop on empty: never generated.
// - FSM states: IDLE, START, DATA, STOP (plus PARITY, see CONFIGURATION).
// - IDLE: tx=1, busy=0. When tx_en=1 and FIFO non-empty, pop head into shift reg and go START next cycle.
// - START: tx=0.
// - DATA: tx=shift[0], LSB first; 8 bits.
// - STOP: tx=1.
// - Every state except IDLE lasts exactly CLKS_PER_BIT cycles, timed by baud counter 0..CLKS_PER_BIT-1, then advances.
// - Frame = 10*CLKS_PER_BIT cycles of busy=1. Pop to first START cycle: 1 clk latency.
// - STOP -> IDLE for 1 clk, then next frame may start: back-to-back frames separated by one idle clk.
// - tx_en deasserted mid-frame: current frame completes normally; no new pop until tx_en=1.
// - tx is registered; no combinational path from io_out to tx.
// - Asynchronous reset mid-frame: tx forced 1 at once, FIFO emptied, frame discarded.
// CONFIGURATION
// - Macro LEG_UART_PARITY_EN.
// - Defined: PARITY state inserted between DATA and STOP, one bit time, tx = even parity (XOR of 8 data bits).
//   Frame length 11*CLKS_PER_BIT.
// - Undefined: no PARITY state, 8N1 framing exactly as above.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4, tx_en=1 unless stated)
// - Reset, io_out=8'h00 held 100 clk -> tx=1, busy=0, fifo_level=0 throughout.
// - io_out 00->41 -> busy rises 3 clk later.
//   tx per 4-clk bit: 0,1,0,0,0,0,0,1,0,1; busy=1 for exactly 40 clk.
// - io_out steps 01,02,03,04,05,06 one per clk while tx_en=0 -> fifo_level=4, overflow=1.
//   Then tx_en=1: frames 01,02,03,04 sent in order, 05/06 lost.
// - io_out=55 then 55 rewritten 10 clk later -> exactly one frame; a 55->AA change -> second frame after one idle clk.
// - Assert rst mid-DATA of frame 0x3C -> tx=1 same cycle, fifo_level=0; after release no frame until io_out changes.
// - With LEG_UART_PARITY_EN, io_out=07 -> parity bit 1, frame 44 clk.
//   With LEG_UART_PARITY_EN, io_out=03 -> parity bit 0.

Source files
------------

// File: rtl/leg_io_uart_tx.sv
// Output-port UART: captures each new io_out value into a small FIFO and sends it as 8N1.
// Define LEG_UART_PARITY_EN to insert an even-parity bit (8E1).
module leg_io_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    io_out,
  input  logic                          tx_en,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   LVL_FULL  = (PW+1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef LEG_UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
  logic r_par;
`endif

  logic [7:0]    r_io_q, r_prev_q;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [PW:0]   r_cnt;
  logic          r_ovf;
  logic [2:0]    r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx, r_busy;

  logic w_push, w_pop, w_full, w_empty, w_wr, w_baud_end;

  // A push is a change of the registered bus against the last captured value
  assign w_push     = (r_io_q != r_prev_q);
  assign w_full     = (r_cnt == LVL_FULL);
  assign w_empty    = (r_cnt == '0);
  assign w_pop      = (r_state == S_IDLE) && tx_en && !w_empty;
  assign w_wr       = w_push && (!w_full || w_pop);
  assign w_baud_end = (r_baud == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_io_q   <= 8'h00;
      r_prev_q <= 8'h00;
    end else begin
      r_io_q   <= io_out;
      r_prev_q <= r_io_q;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= r_io_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr)  r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_wr && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_wr && w_pop) r_cnt <= r_cnt - 1'b1;
      if (w_push && !w_wr) r_ovf <= 1'b1;
    end
  end

  // tx/busy are registered from the next state so the line never glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
`ifdef LEG_UART_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rd];
`ifdef LEG_UART_PARITY_EN
            r_par   <= ^r_mem[r_rd];
`endif
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
`ifdef LEG_UART_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_par;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`ifdef LEG_UART_PARITY_EN
        S_PARITY: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_baud  <= '0;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign fifo_level = r_cnt;
  assign overflow   = r_ovf;
endmodule

// File: tb/tb_leg_io_uart_tx.sv
// Scoreboard bench for leg_io_uart_tx: a negedge monitor decodes frames off tx and
// compares them with bytes queued when the stimulus wrote io_out.
module tb_leg_io_uart_tx;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
`ifdef LEG_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] io_out;
  logic       tx_en;
  logic       tx, busy, overflow;
  logic [2:0] fifo_level;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] sb_q[$];

  leg_io_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .io_out(io_out), .tx_en(tx_en),
    .tx(tx), .busy(busy), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame monitor: cnt 0 is the first START cycle; bit k is sampled mid-bit at k*CPB+CPB/2
  bit         mon_on = 0;
  int         mon_cnt = 0;
  logic [7:0] mon_data;
  logic       mon_par;
  int         blen = 0;
  int         idle_run = 0;
  int         last_gap = -1;
  int         frames = 0;

  always @(negedge clk) begin
    if (rst) begin
      mon_on   = 0;
      blen     = 0;
      idle_run = 0;
    end else begin
      if (busy) begin
        if (blen == 0) last_gap = idle_run;
        blen++;
        idle_run = 0;
      end else begin
        if (blen != 0) begin
          chk("busy_len", blen, FRAME);
          blen = 0;
        end
        idle_run++;
      end
      if (!mon_on) begin
        if (tx == 1'b0) begin
          mon_on  = 1;
          mon_cnt = 0;
        end
      end else begin
        mon_cnt++;
      end
      if (mon_on && (mon_cnt % CPB) == CPB / 2) begin
        automatic int k = mon_cnt / CPB;
        if (k == 0) chk("start_bit", tx, 0);
        else if (k <= 8) mon_data[k-1] = tx;
        else if (k == NBITS - 1) begin
          chk("stop_bit", tx, 1);
          frames++;
          if (sb_q.size() == 0) chk("unexpected_frame", mon_data, -1);
          else begin
            automatic logic [7:0] e = sb_q.pop_front();
            chk("frame_data", mon_data, e);
`ifdef LEG_UART_PARITY_EN
            chk("parity_bit", mon_par, ^e);
`endif
          end
          mon_on = 0;
        end else begin
          mon_par = tx;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    tick(4);
    for (int i = 0; i < 3000 && quiet < 4; i++) begin
      @(negedge clk);
      if (!busy && fifo_level == 0) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) chk({tag, "_timeout"}, 1, 0);
    tick(1);
  endtask

  initial begin
    int bad;
    rst = 1'b1; io_out = 8'h00; tx_en = 1'b1;
    tick(3);
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Bus held at 00 after reset must never push
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0) bad++;
    end
    chk("idle_00_violations", bad, 0);

    // 00 -> 41: busy rises on the third edge
    @(posedge clk); #1 io_out = 8'h41; sb_q.push_back(8'h41);
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("busy_pre", busy, 0);
    @(negedge clk);
    chk("busy_rise", busy, 1);
    wait_idle("f41");
    chk("frames_41", frames, 1);

    // Overflow: six distinct writes while held
    tx_en = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      io_out = 8'(v);
      if (v <= DEPTH) sb_q.push_back(8'(v));
      tick(1);
    end
    tick(3);
    @(negedge clk);
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_no_tx", busy, 0);
    tick(1);
    tx_en = 1'b1;
    wait_idle("drain");
    chk("frames_drain", frames, 5);
    chk("ovf_sticky", overflow, 1);

    // Rewriting the same value sends one frame; a real change queues a back-to-back frame
    io_out = 8'h55; sb_q.push_back(8'h55);
    tick(10);
    io_out = 8'h55;
    tick(10);
    io_out = 8'hAA; sb_q.push_back(8'hAA);
    wait_idle("b2b");
    chk("frames_b2b", frames, 7);
    chk("b2b_gap", last_gap, 1);

    // Reset mid-DATA of 0x3C: frame discarded, line released immediately
    io_out = 8'h3C;
    tick(3 + CPB + 3 * CPB);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_busy", busy, 0);
    io_out = 8'h00;  // a nonzero bus held across reset would be captured as new data
    tick(2);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1 || fifo_level !== 3'd0) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    chk("post_rst_ovf", overflow, 0);
    tick(1);
    io_out = 8'h5A; sb_q.push_back(8'h5A);
    wait_idle("post_rst");
    chk("frames_post_rst", frames, 8);

`ifdef LEG_UART_PARITY_EN
    io_out = 8'h07; sb_q.push_back(8'h07);
    wait_idle("par07");
    io_out = 8'h03; sb_q.push_back(8'h03);
    wait_idle("par03");
    chk("frames_par", frames, 10);
`endif

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
